bram_line_fetcher: RTL and testbench

//  Consumer-side neighbour of the AXI-S->BRAM adapter: reads lines [start, bound) from the second port of the 1152-bit line BRAM.

---
 rtl/bram_fetch_pkg.sv | 21 ++
 rtl/bram_line_fetcher_if.sv | 13 +
 rtl/bram_fetch_skid_fifo.sv | 52 +++++
 rtl/bram_line_fetcher.sv | 143 ++++++++++++++
 tb/tb_bram_line_fetcher.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bram_fetch_pkg.sv
// Shared constants and types for the BRAM line fetcher: geometry, FSM states and the skid
// FIFO entry layout (line data plus its end-of-pass tag).
package bram_fetch_pkg;

    localparam int unsigned BRAM_DEPTH         = 12;
    localparam int unsigned BRAM_WIDTH_IN_WORD = 36;
    localparam int unsigned BRAM_WIDTH         = 32 * BRAM_WIDTH_IN_WORD;
    localparam int unsigned FIFO_DEPTH         = 2;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } fetch_state_e;

    typedef struct packed {
        logic                  last;
        logic [BRAM_WIDTH-1:0] data;
    } line_entry_t;

endpackage

// File: rtl/bram_line_fetcher_if.sv
// Wide line stream from the fetcher to the compute engine; a transfer is valid & ready.
interface bram_line_fetcher_if;
    import bram_fetch_pkg::*;

    logic                  line_valid;
    logic [BRAM_WIDTH-1:0] line_data;
    logic                  line_last;
    logic                  line_ready;

    modport master (output line_valid, output line_data, output line_last, input line_ready);
    modport slave  (input line_valid, input line_data, input line_last, output line_ready);

endinterface

// File: rtl/bram_fetch_skid_fifo.sv
// Two-entry skid FIFO holding BRAM read data and its last tag; slot 0 is always the head.
module bram_fetch_skid_fifo
    import bram_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        push_i,
    input  line_entry_t din_i,
    input  logic        pop_i,
    output logic        valid_o,
    output line_entry_t dout_o,
    output logic [1:0]  count_o
);

    line_entry_t slot0_q, slot1_q;
    logic [1:0]  cnt_q;

    assign valid_o = (cnt_q != 2'd0);
    assign dout_o  = slot0_q;
    assign count_o = cnt_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            slot0_q <= '0;
            slot1_q <= '0;
            cnt_q   <= 2'd0;
        end else begin
            case ({push_i, pop_i})
                2'b10: begin
                    if (cnt_q == 2'd0) slot0_q <= din_i;
                    else               slot1_q <= din_i;
                    cnt_q <= cnt_q + 2'd1;
                end
                2'b01: begin
                    // Keep the head untouched when it empties so the last value lingers.
                    if (cnt_q == 2'(FIFO_DEPTH)) slot0_q <= slot1_q;
                    cnt_q <= cnt_q - 2'd1;
                end
                2'b11: begin
                    if (cnt_q == 2'(FIFO_DEPTH)) begin
                        slot0_q <= slot1_q;
                        slot1_q <= din_i;
                    end else begin
                        slot0_q <= din_i;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/bram_line_fetcher.sv
// Streams BRAM lines [start, bound) to a wide valid/ready consumer at one line per cycle.
// Define BRAM_FETCH_REPEAT_EN to add repeat_mode/stop for looping over the range.
module bram_line_fetcher
    import bram_fetch_pkg::*;
(
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic [BRAM_DEPTH-1:0] bram_start_index,
    input  logic [BRAM_DEPTH-1:0] bram_bound_index,
`ifdef BRAM_FETCH_REPEAT_EN
    input  logic                  repeat_mode,
    input  logic                  stop,
`endif
    output logic                  busy,
    output logic                  done,
    output logic                  bram_en,
    output logic [BRAM_DEPTH-1:0] bram_index,
    input  logic [BRAM_WIDTH-1:0] bram_out,
    bram_line_fetcher_if.master   line
);

    fetch_state_e          state_q;
    logic                  busy_q, done_q, inflight_q, last_q;
    logic [BRAM_DEPTH-1:0] index_q, remain_q;
`ifdef BRAM_FETCH_REPEAT_EN
    logic [BRAM_DEPTH-1:0] start_idx_q, len_q;
    logic                  rpt_q, stop_q;
`endif

    logic [BRAM_DEPTH-1:0] len_d;
    logic [1:0]            fifo_cnt, occ;
    logic                  head_valid, pop, credit_ok, issue, last_issue, final_pop, keep_going;
    line_entry_t           head, push_entry;

    assign len_d = bram_bound_index - bram_start_index;

    assign pop = head_valid & line.line_ready;
    // Slots in use once this cycle's read lands; a same-cycle pop frees one.
    assign occ       = fifo_cnt + {1'b0, inflight_q};
    assign credit_ok = (occ < 2'(FIFO_DEPTH)) || (pop && occ == 2'(FIFO_DEPTH));
    assign issue      = (state_q == FETCH) && credit_ok;
    assign last_issue = issue && (remain_q == BRAM_DEPTH'(1));
    assign final_pop  = (state_q == DRAIN) && pop && (fifo_cnt == 2'd1) && !inflight_q;

`ifdef BRAM_FETCH_REPEAT_EN
    assign keep_going = rpt_q & ~(stop_q | stop);
`else
    assign keep_going = 1'b0;
`endif

    assign push_entry.last = last_q;
    assign push_entry.data = bram_out;

    bram_fetch_skid_fifo u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (inflight_q),
        .din_i   (push_entry),
        .pop_i   (pop),
        .valid_o (head_valid),
        .dout_o  (head),
        .count_o (fifo_cnt)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            inflight_q <= 1'b0;
            last_q     <= 1'b0;
            index_q    <= '0;
            remain_q   <= '0;
`ifdef BRAM_FETCH_REPEAT_EN
            start_idx_q <= '0;
            len_q       <= '0;
            rpt_q       <= 1'b0;
            stop_q      <= 1'b0;
`endif
        end else begin
            done_q     <= 1'b0;
            inflight_q <= issue;
            last_q     <= last_issue;
            if (issue) begin
                index_q  <= index_q + 1'b1;
                remain_q <= remain_q - 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        index_q  <= bram_start_index;
                        remain_q <= len_d;
`ifdef BRAM_FETCH_REPEAT_EN
                        start_idx_q <= bram_start_index;
                        len_q       <= len_d;
                        rpt_q       <= repeat_mode;
                        stop_q      <= 1'b0;
`endif
                        if (len_d == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q <= FETCH;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    if (last_issue) begin
                        if (keep_going) begin
`ifdef BRAM_FETCH_REPEAT_EN
                            index_q  <= start_idx_q;
                            remain_q <= len_q;
`endif
                        end else begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (final_pop) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
`ifdef BRAM_FETCH_REPEAT_EN
            if (stop && busy_q) stop_q <= 1'b1;
`endif
        end
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign bram_en         = issue;
    assign bram_index      = index_q;
    assign line.line_valid = head_valid;
    assign line.line_data  = head.data;
    assign line.line_last  = head.last;

endmodule

// File: tb/tb_bram_line_fetcher.sv
// Randomized bench for bram_line_fetcher with a queue-based model of the expected line stream.
module tb_bram_line_fetcher;
    import bram_fetch_pkg::*;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic start = 1'b0;
    logic [11:0] bram_start_index = '0;
    logic [11:0] bram_bound_index = '0;
    logic repeat_mode = 1'b0;
    logic stop = 1'b0;
    logic busy, done, bram_en;
    logic [11:0] bram_index;
    logic [BRAM_WIDTH-1:0] bram_out = '0;

    bram_line_fetcher_if lif ();

    bram_line_fetcher dut (
        .clk              (clk),
        .rstn             (rstn),
        .start            (start),
        .bram_start_index (bram_start_index),
        .bram_bound_index (bram_bound_index),
`ifdef BRAM_FETCH_REPEAT_EN
        .repeat_mode      (repeat_mode),
        .stop             (stop),
`endif
        .busy             (busy),
        .done             (done),
        .bram_en          (bram_en),
        .bram_index       (bram_index),
        .bram_out         (bram_out),
        .line             (lif)
    );

    always #5 clk = ~clk;

    function automatic logic [BRAM_WIDTH-1:0] line_of(input logic [11:0] idx);
        logic [BRAM_WIDTH-1:0] v;
        for (int w = 0; w < BRAM_WIDTH_IN_WORD; w++) v[w*32 +: 32] = {idx, 8'(w), ~idx};
        return v;
    endfunction

    always @(posedge clk) if (bram_en) bram_out <= line_of(bram_index);

    int n_chk = 0, n_pass = 0;
    task automatic chk(input bit ok, input string nm, input longint unsigned act,
                       input longint unsigned exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    // Behavioural model: queues of expected issues and expected delivered lines.
    typedef struct { logic [11:0] idx; bit last; } ent_t;
    ent_t iss_q[$], exp_q[$];
    logic [11:0] obs_idx[$];
    bit obs_last[$];
    bit busy_m = 0, done_m = 0, rpt_m = 0, stop_m = 0, stall_prev = 0;
    logic [11:0] st_m, n_m;
    int issued = 0, popped = 0, n_issue = 0, n_done = 0;
    logic [BRAM_WIDTH-1:0] prev_data, ref_line;
    bit prev_last;
    int rdy_mode = 0;

    task automatic push_pass(input logic [11:0] s, input logic [11:0] n);
        ent_t e;
        for (int i = 0; i < int'(n); i++) begin
            e.idx = s + 12'(i);
            e.last = (i == int'(n) - 1);
            iss_q.push_back(e);
            exp_q.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        ent_t e;
        bit hs, fin, acc;
        logic [11:0] n;
        if (!rstn) begin
            chk(!busy, "rst_busy", busy, 0);
            chk(!done, "rst_done", done, 0);
            chk(!bram_en, "rst_bram_en", bram_en, 0);
            chk(bram_index == 0, "rst_bram_index", bram_index, 0);
            chk(!lif.line_valid, "rst_line_valid", lif.line_valid, 0);
            chk(!lif.line_last, "rst_line_last", lif.line_last, 0);
            chk(lif.line_data == '0, "rst_line_data", lif.line_data[63:0], 0);
            iss_q.delete(); exp_q.delete();
            busy_m = 0; done_m = 0; rpt_m = 0; stop_m = 0; stall_prev = 0;
            issued = 0; popped = 0;
        end else begin
            acc = start && !busy_m;
            chk(busy == busy_m, "busy", busy, busy_m);
            chk(done == done_m, "done", done, done_m);
            if (done) n_done++;
            if (stall_prev)
                chk(lif.line_valid && lif.line_data == prev_data && lif.line_last == prev_last,
                    "stall_stable", lif.line_data[63:0], prev_data[63:0]);
            if (rpt_m && stop && busy_m) stop_m = 1;
            if (bram_en) begin
                n_issue++; issued++;
                if (iss_q.size() == 0) chk(0, "spurious_bram_en", bram_index, 0);
                else begin
                    e = iss_q.pop_front();
                    chk(bram_index == e.idx, "bram_index", bram_index, e.idx);
                    if (e.last && iss_q.size() == 0 && rpt_m && !stop_m) push_pass(st_m, n_m);
                end
            end
            hs = lif.line_valid && lif.line_ready;
            fin = 0;
            if (hs) begin
                popped++;
                obs_idx.push_back(lif.line_data[31:20]);
                obs_last.push_back(lif.line_last);
                if (exp_q.size() == 0) chk(0, "extra_line", lif.line_data[31:20], 0);
                else begin
                    e = exp_q.pop_front();
                    ref_line = line_of(e.idx);
                    chk(lif.line_data == ref_line, "line_data", lif.line_data[63:0], ref_line[63:0]);
                    chk(lif.line_last == e.last, "line_last", lif.line_last, e.last);
                    fin = e.last && exp_q.size() == 0 && iss_q.size() == 0;
                end
            end
            if (bram_en) chk(issued - popped <= 2, "outstanding", issued - popped, 2);
            stall_prev = lif.line_valid && !lif.line_ready;
            prev_data = lif.line_data;
            prev_last = lif.line_last;
            done_m = fin;
            if (fin) busy_m = 0;
            if (acc) begin
                n = bram_bound_index - bram_start_index;
                if (n == 0) done_m = 1;
                else begin
                    busy_m = 1; st_m = bram_start_index; n_m = n;
                    rpt_m = repeat_mode; stop_m = 0;
                    push_pass(bram_start_index, n);
                end
            end
        end
    end

    initial begin
        int ph = 0;
        lif.line_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0: lif.line_ready = 1'b1;
                1: begin lif.line_ready = (ph == 0); ph = (ph + 1) % 3; end
                default: lif.line_ready = ($urandom_range(0, 9) < 7);
            endcase
        end
    end

    task automatic launch(input logic [11:0] s, input logic [11:0] b, input bit rpt);
        @(posedge clk); #1;
        start = 1; bram_start_index = s; bram_bound_index = b; repeat_mode = rpt;
        @(posedge clk); #1;
        start = 0; bram_start_index = 12'($urandom); bram_bound_index = 12'($urandom);
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        do begin @(negedge clk); k++; end while (!done && k < budget);
        chk(done, "done_timeout", k, budget);
        repeat (3) @(negedge clk);
        chk(exp_q.size() == 0, "leftover_lines", exp_q.size(), 0);
    endtask

    task automatic check_seq(input int n, input logic [11:0] ex[8], input bit exl[8],
                             input string tag);
        chk(obs_idx.size() == n, {tag, "_count"}, obs_idx.size(), n);
        for (int i = 0; i < n && i < obs_idx.size(); i++) begin
            chk(obs_idx[i] == ex[i], {tag, "_idx"}, obs_idx[i], ex[i]);
            chk(obs_last[i] == exl[i], {tag, "_last"}, obs_last[i], exl[i]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        logic [11:0] ex1[8] = '{12'h010, 12'h011, 12'h012, 12'h013, 0, 0, 0, 0};
        bit          exl1[8] = '{0, 0, 0, 1, 0, 0, 0, 0};
        logic [11:0] ex3[8] = '{12'hFFE, 12'hFFF, 12'h000, 12'h001, 0, 0, 0, 0};
        logic [11:0] ex6[8] = '{12'h020, 12'h021, 12'h020, 12'h021, 12'h020, 12'h021, 0, 0};
        bit          exl6[8] = '{0, 1, 0, 1, 0, 1, 0, 0};
        int lat, gap, d0, i0, k;
        logic [11:0] s, len;

        repeat (3) @(posedge clk);
        #1 rstn = 1;

        // 1: plain run, latency and back-to-back delivery
        rdy_mode = 0; obs_idx.delete(); obs_last.delete();
        launch(12'h010, 12'h014, 0);
        lat = 1;
        k = 0;
        forever begin
            @(negedge clk);
            if (lif.line_valid || k > 20) break;
            @(posedge clk); lat++; k++;
        end
        chk(lat == 3, "t1_latency", lat, 3);
        gap = 0;
        do begin @(negedge clk); gap++; end while (!done && gap < 40);
        chk(gap == 4, "t1_done_gap", gap, 4);
        repeat (3) @(negedge clk);
        check_seq(4, ex1, exl1, "t1");

        // 2: ready pattern 1,0,0
        rdy_mode = 1; obs_idx.delete(); obs_last.delete();
        launch(12'h010, 12'h014, 0);
        wait_done(200);
        check_seq(4, ex1, exl1, "t2");

        // 3: range wrapping through 0xFFF
        rdy_mode = 0; obs_idx.delete(); obs_last.delete();
        launch(12'hFFE, 12'h002, 0);
        wait_done(200);
        check_seq(4, ex3, exl1, "t3");

        // 4: empty range
        d0 = n_done; i0 = n_issue;
        launch(12'h100, 12'h100, 0);
        wait_done(20);
        chk(n_done - d0 == 1, "t4_done_pulses", n_done - d0, 1);
        chk(n_issue == i0, "t4_no_bram_en", n_issue - i0, 0);

        // 5: reset mid-fetch, then a 1-line run
        obs_idx.delete(); obs_last.delete();
        launch(12'h100, 12'h108, 0);
        k = 0;
        while (obs_idx.size() < 2 && k < 100) begin @(negedge clk); k++; end
        chk(obs_idx.size() >= 2, "t5_two_lines", obs_idx.size(), 2);
        @(posedge clk); #1 rstn = 0;
        #1;
        chk(!busy && !done && !bram_en && !lif.line_valid && !lif.line_last,
            "t5_async_ctrl", {busy, done, bram_en, lif.line_valid, lif.line_last}, 0);
        chk(bram_index == 0 && lif.line_data == '0, "t5_async_data", bram_index, 0);
        @(posedge clk); #1 rstn = 1;
        obs_idx.delete(); obs_last.delete();
        launch(12'h000, 12'h001, 0);
        wait_done(100);
        chk(obs_idx.size() == 1, "t5_one_line", obs_idx.size(), 1);
        if (obs_idx.size() > 0) chk(obs_idx[0] == 12'h000 && obs_last[0], "t5_line0",
                                    {obs_last[0], obs_idx[0]}, 13'h1000);

        // randomized ranges and backpressure, with starts injected while busy
        rdy_mode = 2;
        for (int r = 0; r < 25; r++) begin
            s = 12'($urandom);
            len = 12'($urandom_range(0, 12));
            launch(s, s + len, 0);
            if (len != 0 && $urandom_range(0, 1) == 1) begin
                start = 1;
                bram_start_index = 12'($urandom); bram_bound_index = 12'($urandom);
                @(posedge clk); #1 start = 0;
            end
            wait_done(400);
        end

`ifdef BRAM_FETCH_REPEAT_EN
        // 6: repeat mode, stop during the third pass
        rdy_mode = 0; obs_idx.delete(); obs_last.delete();
        launch(12'h020, 12'h022, 1);
        k = 0; i0 = 0;
        while (i0 < 4 && k < 100) begin @(negedge clk); if (bram_en) i0++; k++; end
        while (k < 100) begin @(negedge clk); k++; if (bram_en) break; end
        @(posedge clk); #1 stop = 1;
        @(posedge clk); #1 stop = 0;
        wait_done(200);
        check_seq(6, ex6, exl6, "t6");
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
